internal_bus_arbiter: RTL and testbench
=======================================

# internal_bus_arbiter

- Sequences the 8-bit internal bus by choosing which of N requesters drives it each cycle.
- Produces a registered one-hot select that feeds the internal bus mux's `busSelect`.
- Arbitration is round-robin; a requester may lock the bus for a bounded number of consecutive cycles.
- Consumers qualify bus data with `grantValid`, because an all-zero select leaves the mux defaulting to input 0.

## Interface
Parameters:
- `REQUESTERS`, 4: number of bus requesters, ≥2; equals the bus mux `INPUTS`.
- `MAX_HOLD`, 4: maximum consecutive cycles one owner keeps the grant, ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `req`  in  REQUESTERS  per-requester bus request, level.
- `lock`  in  REQUESTERS  owner asks to keep the bus next cycle; only honoured with `req` for the current owner.
- `grant`  out  REQUESTERS  registered one-hot bus select; all-zero when idle.
- `grantValid`  out  1  high when `grant` is non-zero.
- `grantId`  out  $clog2(REQUESTERS)  binary index of the owner; 0 when idle.
- `holdTimeout`  out  1  one-cycle pulse when a lock is cut off at `MAX_HOLD`.

## Operation
State machine `IDLE` / `GRANTED` / `LOCKED`, plus:
- `ptr`: last granted index.
- `holdCnt`: consecutive cycles owned, range 1..MAX_HOLD.

Round-robin pick: search `req` starting at `ptr+1`, wrapping modulo REQUESTERS; the first set bit wins. Each new grant sets `ptr` to the winner and `holdCnt` to 1.

Transitions:
- `IDLE`:
  - any `req` → `GRANTED`, grant to the winner.
  - otherwise stay; outputs zero.
- `GRANTED` / `LOCKED`, evaluated at each edge against owner `o`:
  - `req[o] & lock[o]` and `holdCnt < MAX_HOLD` → `LOCKED`, same grant, `holdCnt++`.
  - `req[o] & lock[o]` and `holdCnt == MAX_HOLD` → forced release: pulse `holdTimeout`, then re-arbitrate.
  - otherwise → re-arbitrate.
- Re-arbitrate:
  - any `req` → `GRANTED` to the winner. This may be `o` again if it is the only requester; `holdCnt` restarts at 1.
  - no `req` → `IDLE`.

Other rules:
- Without a lock, an owner holds the bus for exactly one cycle per win.
- Requests and locks from non-owners are ignored except in the pick.
- `lock` without `req` is ignored.
- `grant`, `grantId` and `grantValid` always agree. `grant` is never multi-hot.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: `req` sampled at edge k → `grant` visible after edge k, one cycle.
- Owner drops `req` → grant moves or clears at the next edge.
- `holdTimeout` is high during the first cycle after the forced-release edge, the same cycle the new grant appears, for exactly one cycle.
- Simultaneous requests are resolved only by rotation from `ptr`; there is no fixed priority after reset.
- Reset, asserted at any time including mid-`LOCKED`, takes effect immediately without a clock edge:
  - state `IDLE`.
  - `grant=0`, `grantValid=0`, `grantId=0`, `holdTimeout=0`.
  - `holdCnt=0`.
  - `ptr=REQUESTERS-1`, so index 0 wins first.
- Index arithmetic wraps modulo REQUESTERS. `holdCnt` width is $clog2(MAX_HOLD+1) and never exceeds MAX_HOLD.

## Structure
- Shared package `internal_bus_pkg`: holds the `bus_arb_state_t` enum (`IDLE`, `GRANTED`, `LOCKED`).
- One combinational sub-module `rr_priority_picker`:
  - inputs: `req`, `ptr`.
  - outputs: winner one-hot, winner index, `anyReq`.
  - The arbiter instantiates it once; the FSM and counters stay in the top module.

## Test plan
Defaults: REQUESTERS=4, MAX_HOLD=4.
1. Hold `nrst` low with random inputs → `grant=0000`, `grantValid=0`, `grantId=0`, `holdTimeout=0` throughout.
2. From `IDLE`, `req=0101` held, `lock=0` → one cycle later the grant sequence is 0001, 0100, 0001, 0100, …
3. `req=1111`, `lock=0010` → owner 1 holds for 4 cycles, then `holdTimeout` pulses once with `grant=0100`.
4. Owner 1 locked, drops `req[1]` after 2 cycles → next edge `grant=0100`, no `holdTimeout`.
5. Assert `nrst` mid-`LOCKED` between edges → outputs clear immediately. After release, `req=1111` → first grant is 0001.
6. `req` goes to 0000 while granted → next edge `grantValid=0`, `grant=0000`, state `IDLE`.

Source files
------------

// File: rtl/internal_bus_pkg.sv
// Shared definitions for the internal bus arbiter and its picker.
package internal_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } bus_arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_priority_picker #(
  parameter int REQUESTERS = 4
) (
  input  logic [REQUESTERS-1:0]         req,
  input  logic [$clog2(REQUESTERS)-1:0] ptr,
  output logic [REQUESTERS-1:0]         winner,
  output logic [$clog2(REQUESTERS)-1:0] winnerId,
  output logic                          anyReq
);

  localparam int IDW = $clog2(REQUESTERS);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    winner   = '0;
    winnerId = '0;
    found    = 1'b0;
    idx      = '0;
    // ptr itself is searched last, so the previous owner has lowest priority
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx = IDW'((int'(ptr) + i) % REQUESTERS);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winnerId    = idx;
      end
    end
  end

  assign anyReq = |req;

endmodule

// File: rtl/internal_bus_arbiter.sv
// Round-robin arbiter for the 8-bit internal bus with bounded owner lock.
module internal_bus_arbiter
  import internal_bus_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int MAX_HOLD   = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [REQUESTERS-1:0]         req,
  input  logic [REQUESTERS-1:0]         lock,
  output logic [REQUESTERS-1:0]         grant,
  output logic                          grantValid,
  output logic [$clog2(REQUESTERS)-1:0] grantId,
  output logic                          holdTimeout
);

  localparam int IDW = $clog2(REQUESTERS);
  localparam int CW  = $clog2(MAX_HOLD + 1);

  bus_arb_state_t         state, state_nx;
  logic [IDW-1:0]         ptr, ptr_nx;
  logic [CW-1:0]          hold_cnt, hold_cnt_nx;
  logic [REQUESTERS-1:0]  grant_nx;
  logic [IDW-1:0]         id_nx;
  logic                   timeout_nx;
  logic                   owner_lock;

  logic [REQUESTERS-1:0]  win_oh;
  logic [IDW-1:0]         win_id;
  logic                   any_req;

  rr_priority_picker #(
    .REQUESTERS(REQUESTERS)
  ) u_picker (
    .req      (req),
    .ptr      (ptr),
    .winner   (win_oh),
    .winnerId (win_id),
    .anyReq   (any_req)
  );

  assign owner_lock = (state != IDLE) && req[grantId] && lock[grantId];

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    hold_cnt_nx = hold_cnt;
    grant_nx    = grant;
    id_nx       = grantId;
    timeout_nx  = 1'b0;
    if (owner_lock && (hold_cnt < CW'(MAX_HOLD))) begin
      state_nx    = LOCKED;
      hold_cnt_nx = hold_cnt + CW'(1);
    end else begin
      // A lock that reaches MAX_HOLD is cut off and flagged for one cycle
      timeout_nx = owner_lock;
      if (any_req) begin
        state_nx    = GRANTED;
        grant_nx    = win_oh;
        id_nx       = win_id;
        ptr_nx      = win_id;
        hold_cnt_nx = CW'(1);
      end else begin
        state_nx    = IDLE;
        grant_nx    = '0;
        id_nx       = '0;
        hold_cnt_nx = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      ptr         <= IDW'(REQUESTERS - 1);
      hold_cnt    <= '0;
      grant       <= '0;
      grantValid  <= 1'b0;
      grantId     <= '0;
      holdTimeout <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      hold_cnt    <= hold_cnt_nx;
      grant       <= grant_nx;
      grantValid  <= |grant_nx;
      grantId     <= id_nx;
      holdTimeout <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_internal_bus_arbiter.sv
// Randomised and directed bench for internal_bus_arbiter against a behavioural model.
module tb_internal_bus_arbiter;

  localparam int R   = 4;
  localparam int MH  = 4;
  localparam int IDW = 2;
  localparam int OW  = R + IDW + 2;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [R-1:0]   req = '0;
  logic [R-1:0]   lock = '0;
  logic [R-1:0]   grant;
  logic           grantValid;
  logic [IDW-1:0] grantId;
  logic           holdTimeout;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: owner index (-1 when idle), last winner, cycles owned
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  logic m_to;

  internal_bus_arbiter #(.REQUESTERS(R), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .grantValid  (grantValid),
    .grantId     (grantId),
    .holdTimeout (holdTimeout)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] model_out();
    logic [R-1:0]   g;
    logic [IDW-1:0] id;
    g  = '0;
    id = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      id         = IDW'(m_owner);
    end
    return {g, (m_owner >= 0), id, m_to};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {grant, grantValid, grantId, holdTimeout};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = R - 1;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [R-1:0] r, input logic [R-1:0] l);
    bit keep;
    bit to;
    int w;
    keep = 0;
    to   = 0;
    if (m_owner >= 0 && r[m_owner] && l[m_owner]) begin
      if (m_hold < MH) keep = 1;
      else             to   = 1;
    end
    if (keep) begin
      m_hold++;
    end else begin
      w = -1;
      for (int k = 1; k <= R; k++)
        if (w < 0 && r[(m_ptr + k) % R]) w = (m_ptr + k) % R;
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_hold  = 1;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end
    m_to = to;
  endtask

  task automatic drive(input logic [R-1:0] r, input logic [R-1:0] l);
    req  = r;
    lock = l;
    @(posedge clk);
    model_step(r, l);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req  = '0;
    lock = '0;
    @(posedge clk);
    #1;
    model_reset();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req  = R'($urandom);
      lock = R'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if (dut_out() !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got %b expected %b", i, dut_out(), {OW{1'b0}});
      end
    end
    model_reset();
  endtask

  task automatic test_alternate();
    logic [R-1:0] eg;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b0101, 4'b0000);
      eg = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      tests++;
      if (grant !== eg || grantValid !== 1'b1 || holdTimeout !== 1'b0) begin
        fails++;
        $display("FAIL alternate cyc%0d: got grant=%b valid=%b to=%b expected grant=%b valid=1 to=0",
                 i, grant, grantValid, holdTimeout, eg);
      end
      tests++;
      if (dut_out() !== model_out()) begin
        fails++;
        $display("FAIL alternate_model cyc%0d: got %b expected %b", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_lock_timeout();
    logic [R-1:0] tbl [7];
    int pulses;
    tbl = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    pulses = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(4'b1111, 4'b0010);
      if (holdTimeout === 1'b1) pulses++;
      tests++;
      if (grant !== tbl[i] || holdTimeout !== (i == 5)) begin
        fails++;
        $display("FAIL lock_timeout cyc%0d: got grant=%b to=%b expected grant=%b to=%b",
                 i, grant, holdTimeout, tbl[i], (i == 5));
      end
      tests++;
      if (dut_out() !== model_out()) begin
        fails++;
        $display("FAIL lock_timeout_model cyc%0d: got %b expected %b", i, dut_out(), model_out());
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL timeout_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    for (int i = 0; i < 3; i++) drive(4'b1111, 4'b0010);
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL lock_drop_owner: got grant=%b expected 0010", grant);
    end
    drive(4'b1101, 4'b0010);
    tests++;
    if (grant !== 4'b0100 || holdTimeout !== 1'b0 || grantId !== 2'd2) begin
      fails++;
      $display("FAIL lock_drop: got grant=%b id=%0d to=%b expected grant=0100 id=2 to=0",
               grant, grantId, holdTimeout);
    end
    tests++;
    if (dut_out() !== model_out()) begin
      fails++;
      $display("FAIL lock_drop_model: got %b expected %b", dut_out(), model_out());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive(4'b1111, 4'b0010);
    #3;
    nrst = 1'b0;
    #1;
    tests++;
    if (dut_out() !== '0) begin
      fails++;
      $display("FAIL async_reset: got %b expected %b", dut_out(), {OW{1'b0}});
    end
    model_reset();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    drive(4'b1111, 4'b0000);
    tests++;
    if (grant !== 4'b0001 || grantId !== 2'd0 || grantValid !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_first: got grant=%b id=%0d valid=%b expected grant=0001 id=0 valid=1",
               grant, grantId, grantValid);
    end
  endtask

  task automatic test_idle();
    do_reset();
    drive(4'b0010, 4'b0000);
    tests++;
    if (grant !== 4'b0010 || grantId !== 2'd1 || grantValid !== 1'b1) begin
      fails++;
      $display("FAIL idle_grant: got grant=%b id=%0d valid=%b expected grant=0010 id=1 valid=1",
               grant, grantId, grantValid);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000, 4'b1111);
      tests++;
      if (dut_out() !== '0 || dut_out() !== model_out()) begin
        fails++;
        $display("FAIL idle_clear cyc%0d: got %b expected %b", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_random();
    logic [R-1:0] r;
    logic [R-1:0] l;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 7) == 0) ? '0 : R'($urandom);
      l = R'($urandom) | (($urandom_range(0, 2) != 0) ? r : '0);
      drive(r, l);
      tests++;
      if (dut_out() !== model_out()) begin
        fails++;
        $display("FAIL random cyc%0d: got %b expected %b (req=%b lock=%b)",
                 i, dut_out(), model_out(), r, l);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alternate();
    test_lock_timeout();
    test_lock_drop();
    test_async_reset();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
